// File: rtl/bus_route_arb.sv
// bus_route_arb: two-master round-robin front end for a bank of register slaves.
// Registered command stage toward the slaves, tracked two-stage read-return
// pipeline that steers slave read data back to the issuing master, and a
// decode-error response for address regions with no slave behind them.
module bus_route_arb #(
  parameter int          AW       = 16,
  parameter int          DW       = 16,
  parameter int          N_SLV    = 3,
  parameter int          SEL_W    = $clog2(N_SLV),
  parameter logic [15:0] ERR_DATA = 16'hDEAD
) (
  input  logic                clk,
  input  logic                rst_n,
  // master 0
  input  logic                bus_cmd_valid_mst0,
  input  logic                bus_op_mst0,
  input  logic [AW-1:0]       bus_addr_mst0,
  input  logic [DW-1:0]       bus_wr_data_mst0,
  output logic                bus_ready_mst0,
  output logic                bus_rd_valid_mst0,
  output logic [DW-1:0]       bus_rd_data_mst0,
  output logic                bus_err_mst0,
  // master 1
  input  logic                bus_cmd_valid_mst1,
  input  logic                bus_op_mst1,
  input  logic [AW-1:0]       bus_addr_mst1,
  input  logic [DW-1:0]       bus_wr_data_mst1,
  output logic                bus_ready_mst1,
  output logic                bus_rd_valid_mst1,
  output logic [DW-1:0]       bus_rd_data_mst1,
  output logic                bus_err_mst1,
  // slave side
  output logic [N_SLV-1:0]    bus_cmd_valid_slv,
  output logic                bus_op_slv,
  output logic [AW-1:0]       bus_addr_slv,
  output logic [DW-1:0]       bus_wr_data_slv,
  input  logic [N_SLV*DW-1:0] bus_rd_data_slv
);

  // Error word, zero-extended or truncated to the data width.
  localparam logic [DW-1:0] ERR_WORD = DW'(ERR_DATA);

  logic             rr;
  logic             grant0, grant1, accept;
  logic             sel_op;
  logic [AW-1:0]    sel_addr, addr_masked;
  logic [DW-1:0]    sel_wr_data;
  logic [SEL_W-1:0] idx;
  logic             hit;
  logic [N_SLV-1:0] strobe_next;
  logic [DW-1:0]    slv_data [N_SLV];

  // Read-tracking pipeline: stage 1 lines up with the slave strobe,
  // stage 2 with the cycle the slave presents its registered data.
  logic             s1_valid, s1_mst, s1_err;
  logic [SEL_W-1:0] s1_idx;
  logic             s2_valid, s2_mst, s2_err;
  logic [SEL_W-1:0] s2_idx;
  logic [DW-1:0]    ret_data;

  // A lone requester always wins; on contention the pointer decides.
  assign grant0 = bus_cmd_valid_mst0 & (~bus_cmd_valid_mst1 | ~rr);
  assign grant1 = bus_cmd_valid_mst1 & (~bus_cmd_valid_mst0 |  rr);
  assign accept = grant0 | grant1;

  assign bus_ready_mst0 = grant0;
  assign bus_ready_mst1 = grant1;

  // Select the winning master's command and decode its slave index.
  always_comb begin
    sel_op      = grant1 ? bus_op_mst1      : bus_op_mst0;
    sel_addr    = grant1 ? bus_addr_mst1    : bus_addr_mst0;
    sel_wr_data = grant1 ? bus_wr_data_mst1 : bus_wr_data_mst0;
    idx         = sel_addr[AW-1 -: SEL_W];
    hit         = int'(idx) < N_SLV;
    addr_masked = sel_addr;
    addr_masked[AW-1 -: SEL_W] = '0;
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_SLV; gi++) begin : g_slv
      assign strobe_next[gi] = accept & hit & (idx == SEL_W'(gi));
      assign slv_data[gi]    = bus_rd_data_slv[gi*DW +: DW];
    end
  endgenerate

  // Pick the returning slave's word, or the error word for unmapped reads.
  always_comb begin
    ret_data = s2_err ? ERR_WORD : '0;
    for (int k = 0; k < N_SLV; k++) begin
      if (!s2_err && s2_idx == SEL_W'(k)) ret_data = slv_data[k];
    end
  end

  // Round-robin pointer flips on every accepted command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rr <= 1'b0;
    else if (accept) rr <= ~rr;
  end

  // Registered command stage; strobe is a single-cycle pulse per accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_cmd_valid_slv <= '0;
      bus_op_slv        <= 1'b0;
      bus_addr_slv      <= '0;
      bus_wr_data_slv   <= '0;
    end else begin
      bus_cmd_valid_slv <= strobe_next;
      if (accept) begin
        bus_op_slv      <= sel_op;
        bus_addr_slv    <= addr_masked;
        bus_wr_data_slv <= sel_wr_data;
      end
    end
  end

  // Shift read tags down the pipeline; writes never enter it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0; s1_mst <= 1'b0; s1_err <= 1'b0; s1_idx <= '0;
      s2_valid <= 1'b0; s2_mst <= 1'b0; s2_err <= 1'b0; s2_idx <= '0;
    end else begin
      s1_valid <= accept & ~sel_op;
      s1_mst   <= grant1;
      s1_err   <= ~hit;
      s1_idx   <= idx;
      s2_valid <= s1_valid;
      s2_mst   <= s1_mst;
      s2_err   <= s1_err;
      s2_idx   <= s1_idx;
    end
  end

  // Deliver the return to the issuing master; data holds between returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_rd_valid_mst0 <= 1'b0; bus_err_mst0 <= 1'b0; bus_rd_data_mst0 <= '0;
      bus_rd_valid_mst1 <= 1'b0; bus_err_mst1 <= 1'b0; bus_rd_data_mst1 <= '0;
    end else begin
      bus_rd_valid_mst0 <= s2_valid & ~s2_mst;
      bus_err_mst0      <= s2_valid & ~s2_mst & s2_err;
      bus_rd_valid_mst1 <= s2_valid &  s2_mst;
      bus_err_mst1      <= s2_valid &  s2_mst & s2_err;
      if (s2_valid && !s2_mst) bus_rd_data_mst0 <= ret_data;
      if (s2_valid &&  s2_mst) bus_rd_data_mst1 <= ret_data;
    end
  end

endmodule

// File: tb/tb_bus_route_arb.sv
// Directed bench for bus_route_arb: default instance plus N_SLV=2 / N_SLV=8
// instances at 32-bit data. Inputs change on the falling edge, outputs are
// read 1 time unit later.
module tb_bus_route_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  // ---------------- default instance (AW=16, DW=16, N_SLV=3) ----------------
  logic        v0 = 0, op0 = 0, v1 = 0, op1 = 0;
  logic [15:0] a0 = 0, wd0 = 0, a1 = 0, wd1 = 0;
  logic        rdy0, rdy1, rv0, rv1, er0, er1, ops;
  logic [15:0] rd0, rd1, as, wds;
  logic [2:0]  cvs;
  logic [47:0] rds = '0;

  bus_route_arb dut (
    .clk(clk), .rst_n(rst_n),
    .bus_cmd_valid_mst0(v0), .bus_op_mst0(op0), .bus_addr_mst0(a0), .bus_wr_data_mst0(wd0),
    .bus_ready_mst0(rdy0), .bus_rd_valid_mst0(rv0), .bus_rd_data_mst0(rd0), .bus_err_mst0(er0),
    .bus_cmd_valid_mst1(v1), .bus_op_mst1(op1), .bus_addr_mst1(a1), .bus_wr_data_mst1(wd1),
    .bus_ready_mst1(rdy1), .bus_rd_valid_mst1(rv1), .bus_rd_data_mst1(rd1), .bus_err_mst1(er1),
    .bus_cmd_valid_slv(cvs), .bus_op_slv(ops), .bus_addr_slv(as), .bus_wr_data_slv(wds),
    .bus_rd_data_slv(rds)
  );

  // Registered slaves: present their word the cycle after the strobe, 0 otherwise.
  always @(posedge clk) begin
    rds <= {cvs[2] ? 16'hCCCC : 16'h0, cvs[1] ? 16'h1234 : 16'h0, cvs[0] ? 16'hAAAA : 16'h0};
  end

  // ---------------- sweep instances (DW=32) ----------------
  logic        zb = 1'b0;
  logic [15:0] z16 = '0;
  logic [31:0] z32 = '0;

  logic        pv = 0;
  logic [15:0] pa = 0;
  logic        p_rdy0, p_rdy1, p_rv0, p_rv1, p_er0, p_er1, p_ops;
  logic [31:0] p_rd0, p_rd1, p_wds;
  logic [15:0] p_as;
  logic [1:0]  p_cvs;
  logic [63:0] p_rds = '0;

  bus_route_arb #(.AW(16), .DW(32), .N_SLV(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .bus_cmd_valid_mst0(pv), .bus_op_mst0(zb), .bus_addr_mst0(pa), .bus_wr_data_mst0(z32),
    .bus_ready_mst0(p_rdy0), .bus_rd_valid_mst0(p_rv0), .bus_rd_data_mst0(p_rd0), .bus_err_mst0(p_er0),
    .bus_cmd_valid_mst1(zb), .bus_op_mst1(zb), .bus_addr_mst1(z16), .bus_wr_data_mst1(z32),
    .bus_ready_mst1(p_rdy1), .bus_rd_valid_mst1(p_rv1), .bus_rd_data_mst1(p_rd1), .bus_err_mst1(p_er1),
    .bus_cmd_valid_slv(p_cvs), .bus_op_slv(p_ops), .bus_addr_slv(p_as), .bus_wr_data_slv(p_wds),
    .bus_rd_data_slv(p_rds)
  );

  logic        qv = 0;
  logic [15:0] qa = 0;
  logic        q_rdy0, q_rdy1, q_rv0, q_rv1, q_er0, q_er1, q_ops;
  logic [31:0] q_rd0, q_rd1, q_wds;
  logic [15:0] q_as;
  logic [7:0]  q_cvs;
  logic [255:0] q_rds = '0;

  bus_route_arb #(.AW(16), .DW(32), .N_SLV(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .bus_cmd_valid_mst0(qv), .bus_op_mst0(zb), .bus_addr_mst0(qa), .bus_wr_data_mst0(z32),
    .bus_ready_mst0(q_rdy0), .bus_rd_valid_mst0(q_rv0), .bus_rd_data_mst0(q_rd0), .bus_err_mst0(q_er0),
    .bus_cmd_valid_mst1(zb), .bus_op_mst1(zb), .bus_addr_mst1(z16), .bus_wr_data_mst1(z32),
    .bus_ready_mst1(q_rdy1), .bus_rd_valid_mst1(q_rv1), .bus_rd_data_mst1(q_rd1), .bus_err_mst1(q_er1),
    .bus_cmd_valid_slv(q_cvs), .bus_op_slv(q_ops), .bus_addr_slv(q_as), .bus_wr_data_slv(q_wds),
    .bus_rd_data_slv(q_rds)
  );

  // Sweep slaves return 32'hF0E1_0000 | k, full width, the cycle after their strobe.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) p_rds[k*32 +: 32] <= p_cvs[k] ? (32'hF0E1_0000 | 32'(k)) : 32'h0;
    for (int k = 0; k < 8; k++) q_rds[k*32 +: 32] <= q_cvs[k] ? (32'hF0E1_0000 | 32'(k)) : 32'h0;
  end

  task automatic idle_inputs();
    v0 = 0; op0 = 0; a0 = 0; wd0 = 0;
    v1 = 0; op1 = 0; a1 = 0; wd1 = 0;
    pv = 0; pa = 0; qv = 0; qa = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      v0 = 1'($urandom); op0 = 1'($urandom); a0 = 16'($urandom); wd0 = 16'($urandom);
      v1 = 1'($urandom); op1 = 1'($urandom); a1 = 16'($urandom); wd1 = 16'($urandom);
      #1;
      total++; if ({cvs, ops, as, wds} !== 36'h0) $display("FAIL rst_slv_side: got %h expected 0", {cvs, ops, as, wds}); else passed++;
      total++; if ({rv0, rv1, er0, er1, rd0, rd1} !== 36'h0) $display("FAIL rst_mst_side: got %h expected 0", {rv0, rv1, er0, er1, rd0, rd1}); else passed++;
    end
    total++; if ({p_cvs, p_rv0, p_rd0, q_cvs, q_rv0, q_rd0} !== 76'h0) $display("FAIL rst_sweep: got %h expected 0", {p_cvs, p_rv0, p_rd0, q_cvs, q_rv0, q_rd0}); else passed++;
    @(negedge clk);
    idle_inputs();
    rst_n = 1;
    // First read after release: master 0 reads 0x4010 (slave 1).
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      v0 = (i == 0); op0 = 0; a0 = 16'h4010;
      #1;
      if (i == 0) begin
        total++; if (rdy0 !== 1'b1) $display("FAIL first_ready: got %b expected 1", rdy0); else passed++;
      end
      if (i == 1) begin
        total++; if (cvs !== 3'b010) $display("FAIL first_strobe: got %b expected 010", cvs); else passed++;
        total++; if (as !== 16'h0010) $display("FAIL first_addr: got %h expected 0010", as); else passed++;
      end
      if (i == 2) begin
        total++; if (cvs !== 3'b000) $display("FAIL first_strobe_pulse: got %b expected 000", cvs); else passed++;
      end
      total++; if (rv0 !== (i == 3)) $display("FAIL first_rd_valid[%0d]: got %b expected %b", i, rv0, (i == 3)); else passed++;
      if (i == 3) begin
        $display("rd m0 addr 4010 -> data %h err %b", rd0, er0);
        total++; if (rd0 !== 16'h1234) $display("FAIL first_rd_data: got %h expected 1234", rd0); else passed++;
        total++; if (er0 !== 1'b0) $display("FAIL first_err: got %b expected 0", er0); else passed++;
      end
    end
  endtask

  task automatic test_contention();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      v0 = (i < 4); op0 = 0; a0 = 16'h0000;
      v1 = (i < 4); op1 = 0; a1 = 16'h8000;
      #1;
      if (i < 4) begin
        total++; if ({rdy0, rdy1} !== {(i % 2 == 0), (i % 2 == 1)}) $display("FAIL contend_grant[%0d]: got %b%b expected %b%b", i, rdy0, rdy1, (i % 2 == 0), (i % 2 == 1)); else passed++;
      end
      total++; if (rv0 !== (i == 3 || i == 5)) $display("FAIL contend_rv0[%0d]: got %b expected %b", i, rv0, (i == 3 || i == 5)); else passed++;
      total++; if (rv1 !== (i == 4 || i == 6)) $display("FAIL contend_rv1[%0d]: got %b expected %b", i, rv1, (i == 4 || i == 6)); else passed++;
      if (rv0) begin
        $display("rd m0 addr 0000 -> data %h", rd0);
        total++; if (rd0 !== 16'hAAAA) $display("FAIL contend_rd0[%0d]: got %h expected aaaa", i, rd0); else passed++;
      end
      if (rv1) begin
        $display("rd m1 addr 8000 -> data %h", rd1);
        total++; if (rd1 !== 16'hCCCC) $display("FAIL contend_rd1[%0d]: got %h expected cccc", i, rd1); else passed++;
      end
    end
  endtask

  task automatic test_decode_error();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      v1 = (i == 0 || i == 5); op1 = (i == 5); a1 = 16'hC000;
      #1;
      if (i == 0 || i == 5) begin
        total++; if (rdy1 !== 1'b1) $display("FAIL derr_ready[%0d]: got %b expected 1", i, rdy1); else passed++;
      end
      if (i == 1 || i == 6) begin
        total++; if (cvs !== 3'b000) $display("FAIL derr_strobe[%0d]: got %b expected 000", i, cvs); else passed++;
      end
      total++; if ({rv1, er1} !== {(i == 3), (i == 3)}) $display("FAIL derr_pulse[%0d]: got %b%b expected %b%b", i, rv1, er1, (i == 3), (i == 3)); else passed++;
      if (i >= 3) begin
        total++; if (rd1 !== 16'hDEAD) $display("FAIL derr_data[%0d]: got %h expected dead", i, rd1); else passed++;
      end
      if (i == 3) begin
        $display("rd m1 addr c000 -> data %h err %b", rd1, er1);
        total++; if (rv0 !== 1'b0) $display("FAIL derr_other_master: got %b expected 0", rv0); else passed++;
      end
    end
    $display("wr m1 addr c000 -> dropped");
  endtask

  task automatic test_write();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      v0 = (i == 0); op0 = 1; a0 = 16'h8004; wd0 = 16'h55AA;
      #1;
      if (i == 1) begin
        $display("wr m0 addr 8004 data 55aa -> strobe %b addr %h data %h", cvs, as, wds);
        total++; if (cvs !== 3'b100) $display("FAIL wr_strobe: got %b expected 100", cvs); else passed++;
        total++; if (ops !== 1'b1) $display("FAIL wr_op: got %b expected 1", ops); else passed++;
        total++; if (as !== 16'h0004) $display("FAIL wr_addr: got %h expected 0004", as); else passed++;
        total++; if (wds !== 16'h55AA) $display("FAIL wr_data: got %h expected 55aa", wds); else passed++;
      end
      if (i == 2) begin
        total++; if (cvs !== 3'b000) $display("FAIL wr_strobe_pulse: got %b expected 000", cvs); else passed++;
      end
      total++; if (rv0 !== 1'b0) $display("FAIL wr_no_resp[%0d]: got %b expected 0", i, rv0); else passed++;
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    // A write, then two reads; reset lands two cycles after the first read.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      v0 = (i <= 2); op0 = (i == 0); a0 = (i == 1) ? 16'h4010 : 16'h0000;
      if (i == 3) rst_n = 0;
      if (i == 4) rst_n = 1;
      #1;
      if (i == 3) begin
        total++; if (cvs !== 3'b000) $display("FAIL mid_rst_strobe: got %b expected 000", cvs); else passed++;
      end
      if (i >= 3) begin
        total++; if ({rv0, rv1} !== 2'b00) $display("FAIL mid_rst_no_return[%0d]: got %b%b expected 00", i, rv0, rv1); else passed++;
      end
    end
    @(negedge clk);
    v0 = 1; v1 = 1; op0 = 0; op1 = 0;
    #1;
    total++; if ({rdy0, rdy1} !== 2'b10) $display("FAIL mid_rst_rr: got %b%b expected 10", rdy0, rdy1); else passed++;
    @(negedge clk);
    idle_inputs();
    $display("reads m0 discarded by reset");
  endtask

  task automatic test_sweep2();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pv = (i < 2); pa = (16'(i) << 15) | 16'h0024;
      #1;
      if (i >= 1 && i <= 2) begin
        total++; if (p_cvs !== 2'(1 << (i - 1))) $display("FAIL sw2_strobe[%0d]: got %b expected %b", i, p_cvs, 2'(1 << (i - 1))); else passed++;
        total++; if (p_as !== 16'h0024) $display("FAIL sw2_addr[%0d]: got %h expected 0024", i, p_as); else passed++;
      end
      total++; if (p_rv0 !== (i >= 3 && i <= 4)) $display("FAIL sw2_rv[%0d]: got %b expected %b", i, p_rv0, (i >= 3 && i <= 4)); else passed++;
      if (i >= 3 && i <= 4) begin
        $display("rd n2 slave %0d -> data %h", i - 3, p_rd0);
        total++; if (p_rd0 !== (32'hF0E1_0000 | 32'(i - 3))) $display("FAIL sw2_data[%0d]: got %h expected %h", i, p_rd0, 32'hF0E1_0000 | 32'(i - 3)); else passed++;
      end
    end
  endtask

  task automatic test_sweep8();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      qv = (i < 8); qa = (16'(i) << 13) | 16'h0024;
      #1;
      if (i >= 1 && i <= 8) begin
        total++; if (q_cvs !== 8'(1 << (i - 1))) $display("FAIL sw8_strobe[%0d]: got %b expected %b", i, q_cvs, 8'(1 << (i - 1))); else passed++;
        total++; if (q_as !== 16'h0024) $display("FAIL sw8_addr[%0d]: got %h expected 0024", i, q_as); else passed++;
      end
      total++; if (q_rv0 !== (i >= 3 && i <= 10)) $display("FAIL sw8_rv[%0d]: got %b expected %b", i, q_rv0, (i >= 3 && i <= 10)); else passed++;
      if (i >= 3 && i <= 10) begin
        $display("rd n8 slave %0d -> data %h err %b", i - 3, q_rd0, q_er0);
        total++; if ({q_er0, q_rd0} !== {1'b0, 32'hF0E1_0000 | 32'(i - 3)}) $display("FAIL sw8_data[%0d]: got %b/%h expected 0/%h", i, q_er0, q_rd0, 32'hF0E1_0000 | 32'(i - 3)); else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_decode_error();
    test_write();
    test_reset_midflight();
    test_sweep2();
    test_sweep8();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bus_route_arb.md
# bus_route_arb

Parametrised successor of the single-master bus address decoder. Two bus masters share one bank of `N_SLV` slaves through this block. It provides:
- round-robin arbitration between the masters;
- a registered command stage toward the slaves;
- a tracked read-return pipeline that steers each slave's read data back to the master that issued the read;
- a decode-error response for unmapped address regions.

It sits between the bus masters (CPU model, DMA) and the register slaves in `chip`.

## Interface
Parameters:
- `AW`, 16, address width
- `DW`, 16, data width
- `N_SLV`, 3, number of slaves (2..8)
- `SEL_W`, `$clog2(N_SLV)`, slave-select bits, taken from `addr[AW-1 -: SEL_W]`
- `ERR_DATA`, 16'hDEAD, read data returned on decode error (zero-extended or truncated to `DW`)

Ports (m = 0, 1):
- `clk` in 1 — clock
- `rst_n` in 1 — reset, asynchronous, active-low
- `bus_cmd_valid_mst{m}` in 1 — master request; held until accepted
- `bus_op_mst{m}` in 1 — 1 = write, 0 = read
- `bus_addr_mst{m}` in AW — address
- `bus_wr_data_mst{m}` in DW — write data
- `bus_ready_mst{m}` out 1 — combinational grant; request accepted at the clock edge while valid && ready
- `bus_rd_valid_mst{m}` out 1 — one-cycle read-return pulse
- `bus_rd_data_mst{m}` out DW — read data; valid with `rd_valid`
- `bus_err_mst{m}` out 1 — decode error; valid with `rd_valid`
- `bus_cmd_valid_slv` out N_SLV — one-hot per-slave command strobe (registered)
- `bus_op_slv` out 1 — shared op (registered)
- `bus_addr_slv` out AW — shared address, top `SEL_W` bits cleared (registered)
- `bus_wr_data_slv` out DW — shared write data (registered)
- `bus_rd_data_slv` in N_SLV*DW — slave k read data on bits [k*DW +: DW]

## Operation
Arbitration:
- Priority pointer `rr`; reset value 0 (master 0).
- Only one master valid: that master is granted.
- Both masters valid: master `rr` is granted.
- `rr` toggles after every accepted command, whoever was granted.
- `ready` is deasserted for the master not granted.
- No backpressure from slaves: one command is accepted every cycle.

Decode:
- `idx = addr[AW-1 -: SEL_W]`.
- `idx < N_SLV`: at the accept edge, the command registers load op, address (masked) and write data, and set `bus_cmd_valid_slv[idx]`.
- `idx >= N_SLV`: no slave strobe (the command registers still load). A read is marked as error; a write is silently dropped.

Writes produce no response.

Read tracking:
- A 2-stage shift register carries {valid, master id, slave idx, err} for every accepted read.
- Stage 2 samples `bus_rd_data_slv[idx]`, or `ERR_DATA` if err, into the issuing master's `rd_data`.
- At the same edge it sets that master's `rd_valid` and `err`.
- `rd_valid` and `err` are single-cycle pulses. `rd_data` holds its value until the next return.

Reset:
- Reset values: all slave-side outputs 0, all `rd_valid`, `err` and `rd_data` 0, pipeline cleared, `rr` = 0.
- Reset asserted mid-operation discards in-flight reads; no `rd_valid` is produced for them.

## Timing
- Cycle T: master valid && ready. Edge end-of-T: accept.
- Cycle T+1: `bus_cmd_valid_slv[idx]` high for exactly one cycle.
- Cycle T+2: slave drives read data (registered slave). The block samples it at the edge end-of-T+2.
- Read latency: `rd_valid` high in cycle T+3, i.e. 3 cycles after accept.
- Back-to-back reads return in issue order, one per cycle.
- Both masters can receive returns in consecutive cycles; a master never receives two returns in the same cycle.
- `bus_ready_mst{m}` is purely combinational from the valids and `rr`; no combinational path from slave inputs to master outputs.

## Test plan
- Reset: hold `rst_n` low with random inputs → all outputs 0. After release, master 0 read of 0x4010 → `bus_cmd_valid_slv` = 3'b010 and `bus_addr_slv` = 0x0010 in T+1; `rd_valid_mst0` in T+3 with slave-1 data 0x1234.
- Contention: both masters hold reads to slaves 0 and 2 for 4 cycles → grants alternate 0,1,0,1. Each master gets exactly its own data (0xAAAA / 0xCCCC), in order, at T+3.
- Decode error: master 1 reads 0xC000 → no slave strobe; `rd_valid_mst1` and `err_mst1` = 1, `rd_data_mst1` = 0xDEAD at T+3. A write to 0xC000 → no strobe, no response.
- Writes: master 0 writes 0x55AA to 0x8004 → slave 2 strobe in T+1 with op = 1, addr 0x0004, data 0x55AA. No `rd_valid`.
- Reset mid-flight: issue 2 reads, assert `rst_n` low at T+2 → no `rd_valid` ever appears for them. `rr` returns to 0.
- Parameter sweep: `N_SLV` = 2 and 8, `DW` = 32 → correct decode of every index and full-width data return.
